// File: rtl/rtp_rx_depack_if.sv
// rtp_rx_depack_if
// Byte stream from the UDP receive port plus the DAC-side sample request/response.
//   udp_rec_data_valid / udp_rec_rdata / udp_rec_data_length : packet bytes, first-byte length
//   wav_rden                                                 : DAC sample request pulse
//   wav_out_data / wav_out_valid                             : returned sample, one-cycle valid
// master = UDP stack / DAC driver side, slave = depacketizer.
interface rtp_rx_depack_if;
  logic        udp_rec_data_valid;
  logic [7:0]  udp_rec_rdata;
  logic [15:0] udp_rec_data_length;
  logic        wav_rden;
  logic [15:0] wav_out_data;
  logic        wav_out_valid;

  modport master (
    output udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, wav_rden,
    input  wav_out_data, wav_out_valid
  );

  modport slave (
    input  udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, wav_rden,
    output wav_out_data, wav_out_valid
  );
endinterface

// File: rtl/rtp_rx_depack.sv
// rtp_rx_depack
// Receive-side RTP depacketizer. Checks the RTP header word and SSRC of each packet,
// pushes accepted big-endian 16-bit PCM samples into a sample FIFO and returns one
// sample per DAC request.
// Ports:
//   clk, rst_n      : system clock, asynchronous active-low reset
//   bus (slave)     : UDP byte stream in, DAC request/sample out
//   pkt_ok/pkt_drop : packet accepted / rejected, registered pulse after the last byte
//   seq_gap         : with pkt_ok when the sequence number is not previous+1
//   fifo_overflow   : a sample was dropped on a full FIFO
//   fifo_underflow  : request arrived with the FIFO empty (silence returned)
//   rx_seq          : sequence number of the last accepted packet
//   fifo_level      : samples currently stored
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for the first byte of a packet, length sampled here
// ST_HEADER  | bytes 1..11 of the RTP header, header word and SSRC checked
// ST_PAYLOAD | sample bytes, high byte latched, low byte writes the FIFO
// ST_DISCARD | rejected packet, bytes swallowed until the last one
module rtp_rx_depack #(
  parameter logic [15:0] RTP_HEADER_PARAM = 16'h8080,
  parameter logic [31:0] SSRC             = 32'h12345678,
  parameter int          MAX_UDP_LENGTH   = 960,
  parameter int          FIFO_DEPTH       = 1024,
  localparam int         AW               = $clog2(FIFO_DEPTH),
  localparam int         LW               = AW + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  rtp_rx_depack_if.slave bus,
  output logic           pkt_ok,
  output logic           pkt_drop,
  output logic           seq_gap,
  output logic           fifo_overflow,
  output logic           fifo_underflow,
  output logic [15:0]    rx_seq,
  output logic [LW-1:0]  fifo_level
);

  localparam logic [15:0]   MAX_LEN  = 16'(MAX_UDP_LENGTH);
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  // Marker bit (bit 7 of the first header word) is not part of the compare.
  localparam logic [15:0]   HDR_MASK = 16'hFF7F;

  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD, ST_DISCARD} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;        // index of the next byte within the packet
  logic [15:0] len;        // effective packet length, never 0
  logic        bad, bad_nxt;
  logic [7:0]  b0;
  logic [15:0] seq_cur;
  logic [23:0] ssrc_sh;
  logic [7:0]  hi_byte;
  logic        first_pkt;

  logic        byte_v;
  logic [7:0]  din;
  logic [15:0] len_eff;
  logic        is_last;
  logic        wr_req, ok_nxt, drop_nxt;

  assign byte_v  = bus.udp_rec_data_valid;
  assign din     = bus.udp_rec_rdata;
  assign len_eff = (bus.udp_rec_data_length == 16'd0) ? 16'd1 : bus.udp_rec_data_length;
  assign is_last = (cnt == len - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bad_nxt   = bad;
    wr_req    = 1'b0;
    ok_nxt    = 1'b0;
    drop_nxt  = 1'b0;
    if (byte_v) begin
      case (state)
        ST_IDLE: begin
          bad_nxt = 1'b0;
          // A one-byte packet starts and ends here.
          if (len_eff == 16'd1)
            drop_nxt = 1'b1;
          // Payload length L-12 is odd exactly when L is odd.
          else if (len_eff < 16'd14 || len_eff > MAX_LEN || len_eff[0])
            state_nxt = ST_DISCARD;
          else
            state_nxt = ST_HEADER;
        end
        ST_HEADER: begin
          if (cnt == 16'd1 && (({b0, din} & HDR_MASK) != (RTP_HEADER_PARAM & HDR_MASK)))
            bad_nxt = 1'b1;
          if (cnt == 16'd11) begin
            if ({ssrc_sh, din} != SSRC)
              bad_nxt = 1'b1;
            state_nxt = bad_nxt ? ST_DISCARD : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          wr_req = cnt[0];
          if (is_last) begin
            state_nxt = ST_IDLE;
            ok_nxt    = 1'b1;
          end
        end
        ST_DISCARD: begin
          if (is_last) begin
            state_nxt = ST_IDLE;
            drop_nxt  = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      len       <= 16'd1;
      bad       <= 1'b0;
      b0        <= '0;
      seq_cur   <= '0;
      ssrc_sh   <= '0;
      hi_byte   <= '0;
      first_pkt <= 1'b1;
      rx_seq    <= '0;
      pkt_ok    <= 1'b0;
      pkt_drop  <= 1'b0;
      seq_gap   <= 1'b0;
    end else begin
      bad      <= bad_nxt;
      pkt_ok   <= ok_nxt;
      pkt_drop <= drop_nxt;
      seq_gap  <= ok_nxt && !first_pkt && (seq_cur != rx_seq + 16'd1);
      if (ok_nxt) begin
        rx_seq    <= seq_cur;
        first_pkt <= 1'b0;
      end
      if (byte_v) begin
        if (state == ST_IDLE) begin
          cnt <= 16'd1;
          len <= len_eff;
          b0  <= din;
        end else begin
          cnt <= cnt + 16'd1;
        end
        if (state == ST_HEADER) begin
          case (cnt)
            16'd2:                    seq_cur[15:8] <= din;
            16'd3:                    seq_cur[7:0]  <= din;
            16'd8, 16'd9, 16'd10:     ssrc_sh       <= {ssrc_sh[15:0], din};
            default: ;
          endcase
        end
        if (state == ST_PAYLOAD && !cnt[0])
          hi_byte <= din;
      end
    end
  end

  // Sample FIFO
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          rd_ok, wr_ok;

  assign rd_ok = bus.wav_rden && (fifo_level != '0);
  // A full FIFO still accepts a write when the same cycle pops the head.
  assign wr_ok = wr_req && ((fifo_level != DEPTH_L) || rd_ok);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= {hi_byte, din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fifo_level        <= '0;
      bus.wav_out_data  <= '0;
      bus.wav_out_valid <= 1'b0;
      fifo_underflow    <= 1'b0;
      fifo_overflow     <= 1'b0;
    end else begin
      bus.wav_out_valid <= bus.wav_rden;
      fifo_underflow    <= bus.wav_rden && !rd_ok;
      fifo_overflow     <= wr_req && !wr_ok;
      if (bus.wav_rden)
        bus.wav_out_data <= rd_ok ? mem[rd_ptr] : 16'd0;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: doc/rtp_rx_depack.md
# rtp_rx_depack

Receive-side RTP depacketizer for the audio-over-UDP path. It consumes the byte stream from the UDP receive interface and validates each RTP header: version/flags/payload type, then SSRC. It writes accepted big-endian 16-bit PCM samples into an internal FIFO and hands them to the WM8731 DAC side one sample per request. It is the counterpart of the transmit-side RTP packer and sits between the UDP stack's receive port and the audio DAC driver.

## Interface
- RTP_HEADER_PARAM, 16'h8080, expected first header word; the marker bit (bit 7) is ignored in the compare
- SSRC, 32'h12345678, accepted synchronisation source
- MAX_UDP_LENGTH, 960, largest accepted packet length in bytes
- FIFO_DEPTH, 1024, sample FIFO depth in 16-bit words (power of 2)
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- udp_rec_data_valid  in  1  qualifies udp_rec_rdata, one byte per high cycle
- udp_rec_rdata  in  8  packet byte, RTP header first, MSB-first fields
- udp_rec_data_length  in  16  packet length in bytes; sampled on the first byte of each packet
- wav_rden  in  1  DAC sample request (single-cycle pulse)
- wav_out_data  out  16  signed PCM sample
- wav_out_valid  out  1  one-cycle pulse, wav_out_data updated
- pkt_ok  out  1  pulse, packet accepted (on its last byte)
- pkt_drop  out  1  pulse, packet rejected (on its last byte)
- seq_gap  out  1  pulse with pkt_ok when sequence number != previous+1
- fifo_overflow  out  1  pulse, a sample was dropped because the FIFO was full
- fifo_underflow  out  1  pulse, wav_rden arrived while the FIFO was empty
- rx_seq  out  16  sequence number of the last accepted packet
- fifo_level  out  clog2(FIFO_DEPTH)+1  words currently stored

## Operation
- Byte counter cnt counts valid bytes within a packet. A packet ends on the byte where cnt == L-1, with L = max(sampled length, 1). Bytes may be non-contiguous; no timeout.
- States:
  - IDLE: first valid byte samples L and sets cnt=0. If L<14, L>MAX_UDP_LENGTH, or (L-12) is odd, go to DISCARD; otherwise go to HEADER. If L==1, the packet ends on this byte.
  - HEADER: bytes 0–11 are shifted into header registers. At byte 1, compare {b0,b1} with RTP_HEADER_PARAM, bit 7 masked. At byte 11, compare bytes 8–11 with SSRC. Any mismatch sets a bad flag. At byte 11: bad → DISCARD, else → PAYLOAD.
  - PAYLOAD: even bytes are latched as the sample high byte. On each odd byte, {hi,lo} is written to the FIFO. The last byte → IDLE with pkt_ok.
  - DISCARD: bytes are swallowed; the last byte → IDLE with pkt_drop.
- Validation completes before any payload byte, so a rejected packet writes no samples and no rollback is needed.
- Sequence (bytes 2–3): the first accepted packet after reset never flags seq_gap. After that, seq_gap fires when seq != rx_seq+1 (mod 2^16, so 16'hFFFF→16'h0000 is not a gap). rx_seq updates on every pkt_ok. Timestamp (bytes 4–7) is ignored.
- FIFO write is allowed when level < FIFO_DEPTH, or when full with a same-cycle read. Otherwise the sample is dropped, fifo_overflow pulses, and the packet still completes as pkt_ok.
- Read: wav_rden with level>0 pops the head. With level==0, wav_out_data <= 0 (silence) and fifo_underflow pulses. wav_out_valid pulses in both cases.

## Timing
- Reset values: state IDLE, all pulses 0, wav_out_data 0, rx_seq 0, fifo_level 0, FIFO empty, first-packet flag set.
- A sample written on the low-byte cycle is counted in fifo_level and readable the next cycle.
- wav_out_data and wav_out_valid appear 1 cycle after wav_rden.
- pkt_ok, pkt_drop, and seq_gap are registered: they are high the cycle after the packet's last byte.
- A simultaneous write and read changes fifo_level by 0.
- Reset asserted mid-packet aborts the packet and empties the FIFO. Bytes after release are treated as a new packet start; the upstream stack guarantees this alignment.
- The length input is ignored after the first byte.

## Test plan
- Valid packet: L=960, header 8080, seq 5, SSRC 12345678, payload 474 samples 0x0001..0x01DA → pkt_ok once, fifo_level=474, rx_seq=5. 474 wav_rden pulses return 0x0001..0x01DA in order, then underflow returns 0x0000.
- Wrong SSRC 0x12345679, or header 0x9080 → pkt_drop, fifo_level unchanged. Header 0x8000 vs 0x8080 (marker only) → accepted.
- Length checks: L=13, L=961, and L=15 (odd payload) → pkt_drop, no FIFO writes. L=14 → one sample, pkt_ok.
- Sequence: accept seq 0xFFFE, 0xFFFF, 0x0000 → no seq_gap. Then seq 0x0002 → seq_gap, rx_seq=2.
- Overflow: FIFO_DEPTH=1024, three 474-sample packets with no reads → fifo_level=1024, 398 fifo_overflow pulses, three pkt_ok. A read coinciding with a write at full leaves the level at 1024.
- Reset during the PAYLOAD of a packet → fifo_level=0 and all outputs at reset values. The next full valid packet is accepted normally.
